// File: rtl/icache_controller_pkg.sv
// Shared constants, FSM state encoding and the block word-select helper for the instruction cache.
package icache_controller_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BLOCK_W      = 128;
    localparam int unsigned OFFSET_LSB   = 2;
    localparam int unsigned OFFSET_W     = 2;
    localparam int unsigned INDEX_LSB    = 4;
    localparam int unsigned BLOCK_ADDR_W = ADDR_W - INDEX_LSB;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MEM_READ = 1'b1
    } state_e;

    // Word 0 sits in the low 32 bits of a block.
    function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFFSET_W-1:0] off);
        logic [WORD_W-1:0] w;
        case (off)
            2'd0:    w = blk[31:0];
            2'd1:    w = blk[63:32];
            2'd2:    w = blk[95:64];
            default: w = blk[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/icache_controller_if.sv
// Fetch-side and memory-side bus bundles of the instruction cache.
interface icache_fetch_if;
    import icache_controller_pkg::*;

    logic [ADDR_W-1:0] ADDRESS;
    logic [WORD_W-1:0] INSTRUCTION;
    logic              BUSYWAIT;

    modport master (output ADDRESS, input INSTRUCTION, input BUSYWAIT);
    modport slave  (input ADDRESS, output INSTRUCTION, output BUSYWAIT);
endinterface

interface icache_mem_if;
    import icache_controller_pkg::*;

    logic                    MEM_READ;
    logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS;
    logic [BLOCK_W-1:0]      MEM_READDATA;
    logic                    MEM_BUSYWAIT;

    modport master (output MEM_READ, output MEM_ADDRESS, input MEM_READDATA, input MEM_BUSYWAIT);
    modport slave  (input MEM_READ, input MEM_ADDRESS, output MEM_READDATA, output MEM_BUSYWAIT);
endinterface

// File: rtl/icache_controller_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read, one write port, async valid clear.
module icache_line_array
    import icache_controller_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_BITS   = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_W-1:0]    rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0]    wr_data
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [BLOCK_W-1:0]  data_q [LINES];

    // Only valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache: zero-latency hits, stalls fetch and refills a 4-word block on a miss.
module icache_controller
    import icache_controller_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic           CLK,
    input  logic           RESET,
    icache_fetch_if.slave  fetch,
    icache_mem_if.master   mem
);

    localparam int unsigned TAG_BITS = ADDR_W - INDEX_LSB - INDEX_BITS;

    state_e                  state_q;
    state_e                  state_d;
    logic [BLOCK_ADDR_W-1:0] miss_addr_q;

    logic                    rd_valid;
    logic [TAG_BITS-1:0]     rd_tag;
    logic [BLOCK_W-1:0]      rd_data;
    logic [INDEX_BITS-1:0]   rd_index;
    logic [TAG_BITS-1:0]     req_tag;
    logic                    hit;

    logic                    busywait_c;
    logic                    mem_read_c;
    logic                    miss_load_c;
    logic                    fill_c;
    logic                    unused_addr_bits;

    assign rd_index = fetch.ADDRESS[INDEX_LSB +: INDEX_BITS];
    assign req_tag  = fetch.ADDRESS[ADDR_W-1 -: TAG_BITS];
    assign hit      = rd_valid && (rd_tag == req_tag);

    assign unused_addr_bits = ^fetch.ADDRESS[OFFSET_LSB-1:0];

    icache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk      (CLK),
        .rst_n    (RESET),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_c),
        .wr_index (miss_addr_q[INDEX_BITS-1:0]),
        .wr_tag   (miss_addr_q[BLOCK_ADDR_W-1 -: TAG_BITS]),
        .wr_data  (mem.MEM_READDATA)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Block address of the line being refilled; frozen for the whole fill.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            miss_addr_q <= '0;
        end else if (miss_load_c) begin
            miss_addr_q <= fetch.ADDRESS[ADDR_W-1:INDEX_LSB];
        end
    end

    always_comb begin
        state_d     = state_q;
        busywait_c  = 1'b0;
        mem_read_c  = 1'b0;
        miss_load_c = 1'b0;
        fill_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    busywait_c  = 1'b1;
                    miss_load_c = 1'b1;
                    state_d     = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                busywait_c = 1'b1;
                mem_read_c = 1'b1;
                if (!mem.MEM_BUSYWAIT) begin
                    fill_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Cold cache in reset would otherwise report a miss.
        if (!RESET) begin
            busywait_c = 1'b0;
        end
    end

    assign fetch.BUSYWAIT    = busywait_c;
    assign fetch.INSTRUCTION = (RESET && rd_valid) ? word_sel(rd_data, fetch.ADDRESS[OFFSET_LSB +: OFFSET_W])
                                                   : '0;
    assign mem.MEM_READ      = mem_read_c;
    assign mem.MEM_ADDRESS   = miss_addr_q;

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller: 4-cycle memory stub, expected words queued at drive time.
module tb_icache_controller;
    import icache_controller_pkg::*;

    localparam int unsigned LAT = 4;

    logic CLK;
    logic RESET;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cnt;
    logic [31:0] exp_q [$];

    icache_fetch_if fif ();
    icache_mem_if   mif ();

    icache_controller dut (
        .CLK   (CLK),
        .RESET (RESET),
        .fetch (fif),
        .mem   (mif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [127:0] mem_block(input logic [27:0] ba);
        logic [127:0] blk;
        if (ba == 28'd0) begin
            blk = 128'h44443333_22221111_00000000_AAAA0000;
        end else begin
            for (int w = 0; w < 4; w++) blk[w*32 +: 32] = {8'(8'hC0 + w), ba[23:0]};
        end
        return blk;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [127:0] blk;
        blk = mem_block(addr[31:4]);
        return blk[32'(addr[3:2]) * 32 +: 32];
    endfunction

    // Memory stub: data valid in the LAT-th cycle of MEM_READ.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET || !mif.MEM_READ) cnt <= 0;
        else if (cnt == LAT - 1)     cnt <= 0;
        else                         cnt <= cnt + 1;
    end
    assign mif.MEM_BUSYWAIT = !(mif.MEM_READ && (cnt == LAT - 1));
    assign mif.MEM_READDATA = mem_block(mif.MEM_ADDRESS);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; returns just after a posedge.
    task automatic access(input logic [31:0] addr, input bit miss);
        int n;
        logic [31:0] e;
        fif.ADDRESS = addr;
        exp_q.push_back(mem_word(addr));
        @(negedge CLK);
        if (miss) begin
            check("miss_busywait", 32'(fif.BUSYWAIT), 32'd1);
            check("miss_idle_no_read", 32'(mif.MEM_READ), 32'd0);
            @(negedge CLK);
            check("mem_read", 32'(mif.MEM_READ), 32'd1);
            check("mem_address", 32'(mif.MEM_ADDRESS), 32'(addr[31:4]));
            n = 2;
            while (fif.BUSYWAIT && n < 50) begin
                @(negedge CLK);
                n++;
            end
            check("miss_penalty", 32'(n), 32'(LAT + 2));
        end
        check("busywait", 32'(fif.BUSYWAIT), 32'd0);
        check("mem_read_idle", 32'(mif.MEM_READ), 32'd0);
        e = exp_q.pop_front();
        check("instruction", fif.INSTRUCTION, e);
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_busywait", 32'(fif.BUSYWAIT), 32'd0);
        check("rst_mem_read", 32'(mif.MEM_READ), 32'd0);
        check("rst_instruction", fif.INSTRUCTION, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        int n;
        logic [31:0] e;

        RESET       = 1'b0;
        fif.ADDRESS = 32'h0;
        #4;
        check("reset_busywait", 32'(fif.BUSYWAIT), 32'd0);
        check("reset_mem_read", 32'(mif.MEM_READ), 32'd0);
        check("reset_instruction", fif.INSTRUCTION, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        access(32'h0, 1'b1);

        // Cold miss mid-block, then hits across the same line
        pulse_reset();
        access(32'h8, 1'b1);
        access(32'h0, 1'b0);
        access(32'h4, 1'b0);
        access(32'hC, 1'b0);

        // Conflict on index 0
        access(32'h80, 1'b1);
        access(32'h0, 1'b1);
        access(32'h80, 1'b1);

        // Address moves away during an in-flight fill of block 0
        fif.ADDRESS = 32'h0;
        @(negedge CLK);
        check("sw_busywait", 32'(fif.BUSYWAIT), 32'd1);
        @(negedge CLK);
        check("sw_mem_address0", 32'(mif.MEM_ADDRESS), 32'h0);
        @(posedge CLK);
        #1;
        fif.ADDRESS = 32'h10;
        exp_q.push_back(mem_word(32'h10));
        n = 0;
        do begin @(negedge CLK); n++; end while (mif.MEM_READ && n < 20);
        check("sw_fill_done", 32'(mif.MEM_READ), 32'd0);
        check("sw_busy_after_fill", 32'(fif.BUSYWAIT), 32'd1);
        n = 0;
        do begin @(negedge CLK); n++; end while (!mif.MEM_READ && n < 20);
        check("sw_mem_address1", 32'(mif.MEM_ADDRESS), 32'h1);
        n = 0;
        while (fif.BUSYWAIT && n < 20) begin @(negedge CLK); n++; end
        check("sw_busywait_end", 32'(fif.BUSYWAIT), 32'd0);
        e = exp_q.pop_front();
        check("sw_instruction", fif.INSTRUCTION, e);
        @(posedge CLK);
        #1;
        access(32'h0, 1'b0);

        // Reset in the second cycle of a fill aborts it
        fif.ADDRESS = 32'h20;
        @(negedge CLK);
        check("ab_busywait", 32'(fif.BUSYWAIT), 32'd1);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        check("ab_mem_read_before", 32'(mif.MEM_READ), 32'd1);
        RESET = 1'b0;
        #1;
        check("ab_mem_read_async", 32'(mif.MEM_READ), 32'd0);
        check("ab_busywait", 32'(fif.BUSYWAIT), 32'd0);
        check("ab_instruction", fif.INSTRUCTION, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        access(32'h20, 1'b1);
        access(32'h24, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
